history_bank_writer: RTL and testbench
======================================

HISTORY_BANK_WRITER -- requirements
Module: history_bank_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, line address width; the bank holds 2^ADDR_WIDTH lines.
REQ-002 SHALL have parameter CLEAR_VAL, default 64'h0, data value written to every line during a clear sweep.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  64  write data from the literal/copy selector output stage.
REQ-006 address_in  input  ADDR_WIDTH  write line address.
REQ-007 byte_valid_in  input  8  byte enables; bit i enables data_in[8i+7:8i].
REQ-008 valid_in  input  1  write strobe; no backpressure, accepted every cycle.
REQ-009 rd_req_valid  input  1  read request strobe.
REQ-010 rd_req_address  input  ADDR_WIDTH  line to read.
REQ-011 rd_data  output  64  read data.
REQ-012 rd_byte_written  output  8  per-byte written-flags of the line read.
REQ-013 rd_data_valid  output  1  rd_data and rd_byte_written are valid.
REQ-014 clear_start  input  1  pulse starting a clear sweep.
REQ-015 clear_busy  output  1  clear sweep in progress.
REQ-016 lines_complete  output  ADDR_WIDTH+1  count of lines with all 8 bytes written.
REQ-017 write_drop_err  output  1  sticky; a write arrived while clearing.
REQ-018 overwrite_err  output  1  sticky; written byte rewritten (see REQ-034).

Function
REQ-019 Storage SHALL be 2^ADDR_WIDTH x 64 data array plus 2^ADDR_WIDTH x 8 written-flag array.
REQ-020 In IDLE, a write SHALL update only enabled bytes of the line and OR byte_valid_in into its flags.
REQ-021 Read latency SHALL be exactly 1 cycle: request in cycle N -> rd_data_valid high in N+1, low otherwise.
REQ-022 Same-cycle write and read to the same line SHALL return merged data: written bytes new, others old; flags likewise merged (write-first).
REQ-023 lines_complete SHALL increment by 1 in the cycle after a write turns a line's flags from not-all-ones to 8'hFF; no increment if line already full.
REQ-024 lines_complete SHALL saturate at 2^ADDR_WIDTH.
REQ-025 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clear_start; CLEAR->IDLE after last line.
REQ-026 CLEAR SHALL sweep one line per cycle from 0 to 2^ADDR_WIDTH-1, writing CLEAR_VAL and flags 0; clear_busy high exactly 2^ADDR_WIDTH cycles starting the cycle after clear_start.
REQ-027 lines_complete SHALL be zero from the first CLEAR cycle.
REQ-028 Writes during CLEAR SHALL be dropped and set write_drop_err.
REQ-029 Reads during CLEAR SHALL be served normally; a read of a line at or below the current sweep index returns cleared content.
REQ-030 clear_start during CLEAR SHALL be ignored.
REQ-031 Address sweep counter SHALL wrap from max to 0 on exit, not overflow into extra bits.

Reset
REQ-032 rst SHALL force: FSM IDLE, rd_data 0, rd_byte_written 0, rd_data_valid 0, clear_busy 0, lines_complete 0, both error flags 0, all written-flags 0; data array not reset.
REQ-033 rst asserted mid-CLEAR SHALL abort the sweep and return to IDLE the next cycle; flags are still zero per REQ-032.

Configuration
REQ-034 With BANK_WRITER_OVERLAP_CHECK_EN defined, overwrite_err SHALL set sticky when a write enables any byte whose flag is already 1 (including REQ-022 same-cycle cases); cleared only by rst.
REQ-035 Without BANK_WRITER_OVERLAP_CHECK_EN, overwrite_err SHALL be tied 0 and no comparison logic built.

Verification
REQ-036 Write addr 5, data 64'h1122334455667788, bv 8'h0F; read 5 next cycle -> rd_data[31:0]=32'h55667788, rd_byte_written=8'h0F, lines_complete 0.
REQ-037 Then write addr 5 bv 8'hF0 with same-cycle read 5 -> rd_data=64'h1122334455667788, rd_byte_written=8'hFF, lines_complete=1 next cycle.
REQ-038 Pulse clear_start -> clear_busy high 512 cycles; write during sweep sets write_drop_err; afterwards read 5 -> 64'h0, flags 8'h00, lines_complete 0.
REQ-039 Fill all 512 lines with bv 8'hFF then rewrite line 0 -> lines_complete stays 512; overwrite_err=1 only with BANK_WRITER_OVERLAP_CHECK_EN.
REQ-040 Assert rst at sweep index 100 -> clear_busy 0 next cycle, all outputs at reset values, fresh clear_start restarts at line 0.

Source files
------------

// File: rtl/history_bank_writer.sv
// history_bank_writer: byte-enabled history line bank with per-byte
// written-flags, write-first 1-cycle read port, clear sweep FSM,
// completed-line counter and sticky error flags.
// Optional build macro: BANK_WRITER_OVERLAP_CHECK_EN enables overwrite_err
// (otherwise overwrite_err is tied low and no comparison logic exists).
//
// state | meaning
// IDLE  | writes and reads served normally
// CLEAR | one line per cycle reset to CLEAR_VAL/flags 0; writes dropped

module history_bank_writer #(
    parameter int          ADDR_WIDTH = 9,
    parameter logic [63:0] CLEAR_VAL  = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           data_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [7:0]            byte_valid_in,
    input  logic                  valid_in,
    input  logic                  rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] rd_req_address,
    output logic [63:0]           rd_data,
    output logic [7:0]            rd_byte_written,
    output logic                  rd_data_valid,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic [ADDR_WIDTH:0]   lines_complete,
    output logic                  write_drop_err,
    output logic                  overwrite_err
);

    localparam int LINES = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LC_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LC_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                state_q;
    logic [63:0]           mem_q   [LINES];
    logic [7:0]            flags_q [LINES];
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   lc_q;
    logic                  busy_q;
    logic                  drop_q;
    logic                  rd_valid_q;
    logic [63:0]           rd_data_q;
    logic [7:0]            rd_flags_q;

    logic        wr_en;
    logic [63:0] wr_mask;
    logic [63:0] wr_cur_data;
    logic [7:0]  wr_cur_flags;
    logic [63:0] wr_data_d;
    logic [7:0]  wr_flags_d;
    logic        line_done;
    logic [63:0] rd_data_d;
    logic [7:0]  rd_flags_d;

    // Expand byte enables into a 64-bit bit mask.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < 8; i++) begin
            wr_mask[8*i +: 8] = {8{byte_valid_in[i]}};
        end
    end

    assign wr_en        = valid_in && (state_q == IDLE);
    assign wr_cur_data  = mem_q[address_in];
    assign wr_cur_flags = flags_q[address_in];
    assign wr_data_d    = (data_in & wr_mask) | (wr_cur_data & ~wr_mask);
    assign wr_flags_d   = wr_cur_flags | byte_valid_in;
    assign line_done    = wr_en && (wr_cur_flags != 8'hFF) && (wr_flags_d == 8'hFF);

    // Read mux: the line being swept this cycle reads as already cleared,
    // and a same-line write this cycle is forwarded (write-first).
    always_comb begin
        rd_data_d  = mem_q[rd_req_address];
        rd_flags_d = flags_q[rd_req_address];
        if ((state_q == CLEAR) && (rd_req_address == idx_q)) begin
            rd_data_d  = CLEAR_VAL;
            rd_flags_d = '0;
        end else if (wr_en && (rd_req_address == address_in)) begin
            rd_data_d  = (data_in & wr_mask) | (rd_data_d & ~wr_mask);
            rd_flags_d = rd_flags_d | byte_valid_in;
        end
    end

    // Data array: no reset; sweep or byte-masked write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[idx_q] <= CLEAR_VAL;
            end else if (wr_en) begin
                mem_q[address_in] <= wr_data_d;
            end
        end
    end

    // Written-flag array: reset to zero, cleared by the sweep, OR-updated by writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                flags_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            flags_q[idx_q] <= '0;
        end else if (wr_en) begin
            flags_q[address_in] <= wr_flags_d;
        end
    end

    // Control FSM with registered status and read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            lc_q       <= '0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_flags_q <= '0;
        end else begin
            rd_valid_q <= rd_req_valid;
            if (rd_req_valid) begin
                rd_data_q  <= rd_data_d;
                rd_flags_q <= rd_flags_d;
            end
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        lc_q    <= '0;
                    end else if (line_done && (lc_q != LC_MAX)) begin
                        lc_q <= lc_q + LC_ONE;
                    end
                end
                CLEAR: begin
                    if (valid_in) begin
                        drop_q <= 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BANK_WRITER_OVERLAP_CHECK_EN
    logic ovl_q;

    // Sticky flag: a write re-enabled a byte that was already written.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_q <= 1'b0;
        end else if (wr_en && (|(byte_valid_in & wr_cur_flags))) begin
            ovl_q <= 1'b1;
        end
    end

    assign overwrite_err = ovl_q;
`else
    assign overwrite_err = 1'b0;
`endif

    assign rd_data         = rd_data_q;
    assign rd_byte_written = rd_flags_q;
    assign rd_data_valid   = rd_valid_q;
    assign clear_busy      = busy_q;
    assign lines_complete  = lc_q;
    assign write_drop_err  = drop_q;

endmodule

// File: tb/tb_history_bank_writer.sv
// Testbench for history_bank_writer: vector table for write/read merging and
// the completed-line counter, plus hand sequences for clear sweep, full fill
// and reset during a sweep. Read expectations go through a scoreboard queue.
// Honours BANK_WRITER_OVERLAP_CHECK_EN for the overwrite_err expectation.

module tb_history_bank_writer;

    localparam int AW    = 9;
    localparam int LINES = 1 << AW;
    localparam logic [63:0] FULL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LOW32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] BYTE0 = 64'h0000_0000_0000_00FF;
`ifdef BANK_WRITER_OVERLAP_CHECK_EN
    localparam logic OV_EXP = 1'b1;
`else
    localparam logic OV_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   data_in;
    logic [AW-1:0] address_in;
    logic [7:0]    byte_valid_in;
    logic          valid_in;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_address;
    logic [63:0]   rd_data;
    logic [7:0]    rd_byte_written;
    logic          rd_data_valid;
    logic          clear_start;
    logic          clear_busy;
    logic [AW:0]   lines_complete;
    logic          write_drop_err;
    logic          overwrite_err;

    always #5 clk = ~clk;

    history_bank_writer #(.ADDR_WIDTH(AW), .CLEAR_VAL(64'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .address_in      (address_in),
        .byte_valid_in   (byte_valid_in),
        .valid_in        (valid_in),
        .rd_req_valid    (rd_req_valid),
        .rd_req_address  (rd_req_address),
        .rd_data         (rd_data),
        .rd_byte_written (rd_byte_written),
        .rd_data_valid   (rd_data_valid),
        .clear_start     (clear_start),
        .clear_busy      (clear_busy),
        .lines_complete  (lines_complete),
        .write_drop_err  (write_drop_err),
        .overwrite_err   (overwrite_err)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic [7:0]  flags;
    } rd_exp_t;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic [7:0]    bv;
        logic          rv;
        logic [AW-1:0] ra;
        logic [63:0]   ed;
        logic [63:0]   em;
        logic [7:0]    ef;
        int            lc;
    } vec_t;

    rd_exp_t exp_q[$];
    vec_t    tbl[10];
    int      n_cmp = 0;
    int      n_err = 0;
    int      cnt;

    function automatic logic [63:0] pat(input int i);
        logic [15:0] a;
        a = 16'(i);
        return {16'hC0DE, a, 16'hBEEF, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One clock; checks read-valid timing and pops the scoreboard on output.
    task automatic tick();
        logic    exp_v;
        rd_exp_t e;
        exp_v = rd_req_valid;
        @(posedge clk);
        #1;
        chk("rd_data_valid", 64'(rd_data_valid), 64'(exp_v));
        if (exp_q.size() == 0) begin
            if (rd_data_valid) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: read output with no expectation queued");
            end
        end else if (exp_v) begin
            e = exp_q.pop_front();
            if (rd_data_valid) begin
                chk("rd_data", rd_data & e.mask, e.data & e.mask);
                chk("rd_byte_written", 64'(rd_byte_written), 64'(e.flags));
            end
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [63:0] d,
                         input logic [7:0] bv, input logic rv, input logic [AW-1:0] ra,
                         input logic [63:0] ed, input logic [63:0] em, input logic [7:0] ef);
        rd_exp_t e;
        valid_in       = v;
        address_in     = a;
        data_in        = d;
        byte_valid_in  = bv;
        rd_req_valid   = rv;
        rd_req_address = ra;
        if (rv) begin
            e.data  = ed;
            e.mask  = em;
            e.flags = ef;
            exp_q.push_back(e);
        end
        tick();
        valid_in     = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    task automatic read_line(input logic [AW-1:0] ra, input logic [63:0] ed, input logic [7:0] ef);
        drive(1'b0, '0, '0, 8'h00, 1'b1, ra, ed, FULL, ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 9'd5,  64'h1122334455667788, 8'h0F, 1'b0, 9'd0,  64'h0,                LOW32, 8'h00, 0};
        tbl[1] = '{1'b0, 9'd0,  64'h0,                8'h00, 1'b1, 9'd5,  64'h0000000055667788, LOW32, 8'h0F, 0};
        tbl[2] = '{1'b1, 9'd5,  64'h1122334455667788, 8'hF0, 1'b1, 9'd5,  64'h1122334455667788, FULL,  8'hFF, 1};
        tbl[3] = '{1'b1, 9'd7,  64'hAABBCCDDEEFF0011, 8'hFF, 1'b1, 9'd5,  64'h1122334455667788, FULL,  8'hFF, 2};
        tbl[4] = '{1'b1, 9'd9,  64'h0123456789ABCDEF, 8'h3C, 1'b1, 9'd7,  64'hAABBCCDDEEFF0011, FULL,  8'hFF, 2};
        tbl[5] = '{1'b1, 9'd9,  64'hFEDCBA9876543210, 8'hC3, 1'b1, 9'd9,  64'hFEDC456789AB3210, FULL,  8'hFF, 3};
        tbl[6] = '{1'b1, 9'd10, 64'h0000000000000055, 8'h01, 1'b1, 9'd10, 64'h0000000000000055, BYTE0, 8'h01, 3};
        tbl[7] = '{1'b0, 9'd0,  64'h0,                8'h00, 1'b0, 9'd0,  64'h0,                FULL,  8'h00, 3};
        tbl[8] = '{1'b0, 9'd0,  64'h0,                8'h00, 1'b1, 9'd9,  64'hFEDC456789AB3210, FULL,  8'hFF, 3};
        tbl[9] = '{1'b1, 9'd5,  64'h0,                8'h00, 1'b1, 9'd5,  64'h1122334455667788, FULL,  8'hFF, 3};

        rst = 1'b1; valid_in = 1'b0; rd_req_valid = 1'b0; clear_start = 1'b0;
        data_in = '0; address_in = '0; byte_valid_in = '0; rd_req_address = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset rd_data", rd_data, 64'h0);
        chk("reset rd_byte_written", 64'(rd_byte_written), 64'h0);
        chk("reset clear_busy", 64'(clear_busy), 64'h0);
        chk("reset lines_complete", 64'(lines_complete), 64'h0);
        chk("reset write_drop_err", 64'(write_drop_err), 64'h0);
        chk("reset overwrite_err", 64'(overwrite_err), 64'h0);

        // Write/read/merge vectors.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].bv, tbl[i].rv, tbl[i].ra,
                  tbl[i].ed, tbl[i].em, tbl[i].ef);
            chk($sformatf("vec%0d lines_complete", i), 64'(lines_complete), 64'(tbl[i].lc));
        end
        chk("no overlap overwrite_err", 64'(overwrite_err), 64'h0);
        chk("idle write_drop_err", 64'(write_drop_err), 64'h0);

        // Clear sweep with reads, a dropped write and an ignored clear_start.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 600) begin
            if (cnt == 0) chk("clear lines_complete first cycle", 64'(lines_complete), 64'h0);
            if (cnt == 5) drive(1'b0, '0, '0, 8'h00, 1'b1, 9'd7, 64'hAABBCCDDEEFF0011, FULL, 8'hFF);
            else if (cnt == 9) drive(1'b0, '0, '0, 8'h00, 1'b1, 9'd9, 64'h0, FULL, 8'h00);
            else if (cnt == 30) drive(1'b1, 9'd3, 64'h1234, 8'hFF, 1'b0, '0, '0, FULL, 8'h00);
            else if (cnt == 20) begin
                clear_start = 1'b1;
                tick();
                clear_start = 1'b0;
            end else tick();
            cnt++;
        end
        chk("clear_busy cycles", 64'(cnt), 64'(LINES));
        chk("write_drop_err", 64'(write_drop_err), 64'h1);
        chk("after clear lines_complete", 64'(lines_complete), 64'h0);
        read_line(9'd5, 64'h0, 8'h00);
        read_line(9'd3, 64'h0, 8'h00);
        read_line(9'd7, 64'h0, 8'h00);

        // Fill every line completely, then rewrite line 0.
        for (int i = 0; i < LINES; i++) begin
            if (i == LINES - 1) chk("fill lines_complete before last", 64'(lines_complete), 64'(LINES - 1));
            drive(1'b1, AW'(i), pat(i), 8'hFF, 1'b0, '0, '0, FULL, 8'h00);
        end
        chk("fill lines_complete", 64'(lines_complete), 64'(LINES));
        chk("fill overwrite_err", 64'(overwrite_err), 64'h0);
        read_line(9'd300, pat(300), 8'hFF);
        drive(1'b1, 9'd0, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1'b1, 9'd0, 64'h5A5A_5A5A_5A5A_5A5A, FULL, 8'hFF);
        chk("rewrite lines_complete", 64'(lines_complete), 64'(LINES));
        chk("rewrite overwrite_err", 64'(overwrite_err), 64'(OV_EXP));

        // Reset during a sweep at index 100, then restart from line 0.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("sweep cycles before reset", 64'(cnt), 64'd100);
        rst = 1'b1;
        tick();
        chk("mid reset clear_busy", 64'(clear_busy), 64'h0);
        chk("mid reset lines_complete", 64'(lines_complete), 64'h0);
        chk("mid reset rd_data", rd_data, 64'h0);
        chk("mid reset rd_byte_written", 64'(rd_byte_written), 64'h0);
        chk("mid reset write_drop_err", 64'(write_drop_err), 64'h0);
        chk("mid reset overwrite_err", 64'(overwrite_err), 64'h0);
        rst = 1'b0;
        tick();
        chk("post reset clear_busy", 64'(clear_busy), 64'h0);
        read_line(9'd150, pat(150), 8'h00);
        read_line(9'd50, 64'h0, 8'h00);

        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 600) begin
            if (cnt == 149) drive(1'b0, '0, '0, 8'h00, 1'b1, 9'd150, pat(150), FULL, 8'h00);
            else if (cnt == 150) drive(1'b0, '0, '0, 8'h00, 1'b1, 9'd150, 64'h0, FULL, 8'h00);
            else tick();
            cnt++;
        end
        chk("restart clear_busy cycles", 64'(cnt), 64'(LINES));
        chk("restart lines_complete", 64'(lines_complete), 64'h0);
        read_line(9'd150, 64'h0, 8'h00);
        chk("scoreboard drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
